shift_seq: RTL and testbench

- Sequencer directly upstream of the 4-bit universal shift register. It drives the register's parallel data and mode-select inputs, and watches its q outputs.
- Accepts a parallel word over a valid/ready handshake, loads it into the register, then shifts it out one bit per accepted serial beat (LSB-first or MSB-first).
- Pulses done when the last bit has been consumed, then returns to idle.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_tx.sv | 57 +++++
 rtl/shift_ureg.sv | 30 +++
 rtl/shift_seq.sv | 115 +++++++++++
 tb/tb_shift_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serialiser sequencer and its universal shift register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

  // Mode-select codes understood by the universal shift register.
  localparam logic [1:0] SR_LOAD = 2'b00;  // q <= d
  localparam logic [1:0] SR_SHL  = 2'b01;  // q[i] <= q[i-1], q[0] <= 0
  localparam logic [1:0] SR_SHR  = 2'b10;  // q[i] <= q[i+1], q[W-1] <= 0
  localparam logic [1:0] SR_HOLD = 2'b11;  // q <= q

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_tx.sv
// Serial transmitter: sequencer plus universal shift register wired together.
// Latency: accept at T, bits at T+2..T+1+WIDTH, done at T+2+WIDTH.
// Backpressure: ser_ready low stalls the current bit; in_ready only while idle.
module shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] sr_d;
  logic [1:0]       sr_s;
  logic [WIDTH-1:0] sr_q;

  shift_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .sr_d      (sr_d),
    .sr_s      (sr_s),
    .sr_q      (sr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .busy      (busy),
    .done      (done)
  );

  shift_ureg #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .s     (sr_s),
    .d     (sr_d),
    .q     (sr_q)
  );

endmodule

// File: rtl/shift_ureg.sv
// Universal shift register: parallel load, shift toward MSB, shift toward LSB, hold.
// Latency: one clock from mode select to q.
// Backpressure: none; the mode select is obeyed every cycle.
module shift_ureg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update selected by the two-bit mode code; zeros fill vacated ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      case (s)
        SR_LOAD: q <= d;
        SR_SHL:  q <= {q[WIDTH-2:0], 1'b0};
        SR_SHR:  q <= {1'b0, q[WIDTH-1:1]};
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequencer: takes a parallel word, loads it into the shift register, streams it bit-serially.
// Latency: accept at T, load at T+1, bits at T+2..T+1+WIDTH, done at T+2+WIDTH.
// Backpressure: ser_ready low holds the register and the current bit; in_ready only in IDLE.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic [WIDTH-1:0] sr_d,
  output logic [1:0]       sr_s,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   data_r;
  logic               dir_r;
  logic               last_bit;
  logic               unused_sr_q;

  // The inner register bits are only seen by the shift register itself.
  assign unused_sr_q = ^sr_q;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Word/direction capture on accept, so later input changes cannot disturb the word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r <= '0;
      dir_r  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      data_r <= in_data;
      dir_r  <= in_dir;
    end
  end

  // Bit counter: cleared during LOAD, advanced only on consumed bits; stops at WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == LOAD) begin
      cnt <= '0;
    end else if (state == SHIFT && ser_ready) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state and control decode; HOLD is the safe default mode.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    sr_s      = SR_HOLD;
    ser_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        sr_s     = SR_LOAD;
        state_nx = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          sr_s = dir_r ? SR_SHR : SR_SHL;
          if (last_bit) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Load data always presents the captured word; only LOAD mode makes the register take it.
  assign sr_d = data_r;

  // The outgoing bit is whichever end of the register the word drains from.
  assign ser_out = dir_r ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_dir;
  logic       ser_ready;

  logic       in_ready;
  logic [3:0] sr_d;
  logic [1:0] sr_s;
  logic [3:0] sr_q;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  logic       t_in_ready;
  logic       t_ser_out;
  logic       t_ser_valid;
  logic       t_busy;
  logic       t_done;

  int errors = 0;
  int checks = 0;

  shift_seq #(.WIDTH(4), .CNT_W(3)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .sr_d      (sr_d),
    .sr_s      (sr_s),
    .sr_q      (sr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .busy      (busy),
    .done      (done)
  );

  shift_ureg #(.WIDTH(4)) u_reg (
    .clk   (clk),
    .reset (reset),
    .s     (sr_s),
    .d     (sr_d),
    .q     (sr_q)
  );

  shift_tx #(.WIDTH(4), .CNT_W(3)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (t_in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .ser_out   (t_ser_out),
    .ser_valid (t_ser_valid),
    .ser_ready (ser_ready),
    .busy      (t_busy),
    .done      (t_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word with ser_ready held high; exp_bits[i] is the i-th bit expected on the wire.
  task automatic run_word(input logic [3:0] d, input logic dir, input logic [3:0] exp_bits,
                          input logic [1:0] exp_s, input string nm);
    in_valid  = 1'b1;
    in_data   = d;
    in_dir    = dir;
    ser_ready = 1'b1;
    #1;
    chk({nm, "_accept_rdy"}, 8'(in_ready), 8'h1);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_dir   = ~dir;
    #1;
    chk({nm, "_load_s"}, 8'(sr_s), 8'h0);
    chk({nm, "_load_d"}, 8'(sr_d), 8'(d));
    chk({nm, "_load_rdy"}, 8'(in_ready), 8'h0);
    chk({nm, "_load_busy"}, 8'(busy), 8'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk({nm, "_bit_vld"}, 8'(ser_valid), 8'h1);
      chk({nm, "_bit"}, 8'(ser_out), 8'(exp_bits[i]));
      chk({nm, "_bit_s"}, 8'(sr_s), 8'(exp_s));
      chk({nm, "_tx_bit"}, 8'(t_ser_out), 8'(exp_bits[i]));
    end
    tick();
    #1;
    chk({nm, "_done"}, 8'(done), 8'h1);
    chk({nm, "_done_vld"}, 8'(ser_valid), 8'h0);
    chk({nm, "_done_s"}, 8'(sr_s), 8'h3);
    chk({nm, "_tx_done"}, 8'(t_done), 8'h1);
    tick();
    #1;
    chk({nm, "_idle_rdy"}, 8'(in_ready), 8'h1);
    chk({nm, "_idle_done"}, 8'(done), 8'h0);
    chk({nm, "_idle_busy"}, 8'(busy), 8'h0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_dir    = 1'b0;
    ser_ready = 1'b1;
    #2;
    // Reset state
    chk("rst_in_ready", 8'(in_ready), 8'h1);
    chk("rst_sr_s", 8'(sr_s), 8'h3);
    chk("rst_sr_d", 8'(sr_d), 8'h0);
    chk("rst_ser_valid", 8'(ser_valid), 8'h0);
    chk("rst_ser_out", 8'(ser_out), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_sr_q", 8'(sr_q), 8'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // LSB-first 1011 -> 1,1,0,1 with SHR
    run_word(4'b1011, 1'b1, 4'b1011, 2'b10, "lsb");

    // MSB-first 1011 -> 1,0,1,1 with SHL (exp_bits[0] is the first bit)
    run_word(4'b1011, 1'b0, 4'b1101, 2'b01, "msb");

    // Backpressure: 0110 LSB-first, two-cycle stall on the second bit
    in_valid  = 1'b1;
    in_data   = 4'b0110;
    in_dir    = 1'b1;
    ser_ready = 1'b1;
    tick();                       // T+1 LOAD
    in_valid = 1'b0;
    tick();                       // T+2
    #1;
    chk("bp_b0", 8'(ser_out), 8'h0);
    chk("bp_b0_s", 8'(sr_s), 8'h2);
    tick();                       // T+3 stall
    ser_ready = 1'b0;
    #1;
    chk("bp_stall1_bit", 8'(ser_out), 8'h1);
    chk("bp_stall1_s", 8'(sr_s), 8'h3);
    chk("bp_stall1_vld", 8'(ser_valid), 8'h1);
    tick();                       // T+4 stall
    #1;
    chk("bp_stall2_bit", 8'(ser_out), 8'h1);
    chk("bp_stall2_s", 8'(sr_s), 8'h3);
    chk("bp_stall2_q", 8'(sr_q), 8'h3);
    chk("bp_stall2_vld", 8'(ser_valid), 8'h1);
    tick();                       // T+5 second bit consumed
    ser_ready = 1'b1;
    #1;
    chk("bp_b1", 8'(ser_out), 8'h1);
    chk("bp_b1_s", 8'(sr_s), 8'h2);
    tick();                       // T+6
    #1;
    chk("bp_b2", 8'(ser_out), 8'h1);
    chk("bp_b2_q", 8'(sr_q), 8'h1);
    tick();                       // T+7
    #1;
    chk("bp_b3", 8'(ser_out), 8'h0);
    chk("bp_b3_done", 8'(done), 8'h0);
    tick();                       // T+8
    #1;
    chk("bp_done", 8'(done), 8'h1);
    tick();

    // Busy-ignore and back-to-back: A accepted, 5 held on the inputs until IDLE
    in_valid = 1'b1;
    in_data  = 4'hA;
    in_dir   = 1'b1;
    tick();                       // T+1 LOAD
    in_data = 4'h5;
    #1;
    chk("b2b_load_d", 8'(sr_d), 8'hA);
    chk("b2b_load_rdy", 8'(in_ready), 8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();                     // T+2..T+5
      #1;
      chk("b2b_a_bit", 8'(ser_out), 8'(i % 2));
      chk("b2b_a_rdy", 8'(in_ready), 8'h0);
    end
    tick();                       // T+6
    #1;
    chk("b2b_a_done", 8'(done), 8'h1);
    chk("b2b_a_done_rdy", 8'(in_ready), 8'h0);
    tick();                       // T+7 accept of 5
    #1;
    chk("b2b_accept_rdy", 8'(in_ready), 8'h1);
    tick();                       // T+8 LOAD
    in_valid = 1'b0;
    #1;
    chk("b2b_load5_d", 8'(sr_d), 8'h5);
    chk("b2b_load5_s", 8'(sr_s), 8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();                     // T+9..T+12
      #1;
      chk("b2b_5_bit", 8'(ser_out), 8'((i + 1) % 2));
    end
    tick();                       // T+13
    #1;
    chk("b2b_5_done", 8'(done), 8'h1);
    tick();

    // Reset mid-shift after the second bit of 1111
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_dir   = 1'b1;
    tick();                       // LOAD
    in_valid = 1'b0;
    tick();                       // bit 0
    #1;
    chk("rm_b0", 8'(ser_out), 8'h1);
    tick();                       // bit 1
    #1;
    chk("rm_b1", 8'(ser_out), 8'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_vld", 8'(ser_valid), 8'h0);
    chk("rm_q", 8'(sr_q), 8'h0);
    chk("rm_rdy", 8'(in_ready), 8'h1);
    chk("rm_busy", 8'(busy), 8'h0);
    chk("rm_done", 8'(done), 8'h0);
    chk("rm_tx_vld", 8'(t_ser_valid), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rm_hold_done", 8'(done), 8'h0);
      chk("rm_hold_vld", 8'(ser_valid), 8'h0);
    end
    reset = 1'b1;
    tick();

    // Next word after reset: 1001 MSB-first -> 1,0,0,1
    run_word(4'b1001, 1'b0, 4'b1001, 2'b01, "post_rst");

    chk("end_tx_busy", 8'(t_busy), 8'h0);
    chk("end_tx_rdy", 8'(t_in_ready), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
